// File: rtl/gd_iter_ctrl.sv
// Iteration controller for the gradient descent regressor: launches evaluations on the shared
// gradient/value unit, steps x by the returned x_diff and stops on convergence, limit or error.
module gd_iter_ctrl #(
    parameter int unsigned MAX_ITER = 256,
    parameter int unsigned ITER_W   = 16,
    parameter logic [31:0] TOL      = 32'h0000_0001,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       x_init,
    output logic              grad_start,
    output logic [31:0]       grad_x,
    input  logic              grad_done,
    input  logic [63:0]       grad_value,
    input  logic [31:0]       grad_x_diff,
    input  logic              grad_overflow,
    output logic              busy,
    output logic              done,
    output logic [31:0]       x_opt,
    output logic [63:0]       value_out,
    output logic [ITER_W-1:0] iter_count,
    output logic [1:0]        status,
    output logic              saturated
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + SETTLE + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StLaunch, StSettle, StWait, StUpdate, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         x_q, x_d;
    logic [31:0]         x_opt_q, x_opt_d;
    logic [63:0]         value_q, value_d;
    logic [31:0]         diff_q, diff_d;
    logic                ovf_q, ovf_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [1:0]          status_q, status_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    timer_q, timer_d;

    logic [32:0]         sub;
    logic [31:0]         x_sat;
    logic                clip;
    logic [31:0]         diff_abs;

    // x - x_diff in 33 bits; a mismatch of the top two bits means the result left the 32-bit range
    always_comb begin
        sub   = {x_q[31], x_q} - {diff_q[31], diff_q};
        clip  = sub[32] != sub[31];
        x_sat = clip ? (sub[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sub[31:0];
        if (diff_q == 32'h8000_0000) begin
            diff_abs = 32'h7FFF_FFFF;
        end else if (diff_q[31]) begin
            diff_abs = -diff_q;
        end else begin
            diff_abs = diff_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        x_opt_d  = x_opt_q;
        value_d  = value_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;
        iter_d   = iter_q;
        status_d = status_q;
        sat_d    = sat_q;
        timer_d  = timer_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x_init;
                    iter_d  = '0;
                    sat_d   = 1'b0;
                    timer_d = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = (SETTLE == 0) ? StWait : StSettle;
            end
            StSettle: begin
                if (timer_q == CNT_W'(SETTLE - 1)) begin
                    timer_d = '0;
                    state_d = StWait;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWait: begin
                if (grad_done) begin
                    value_d = grad_value;
                    diff_d  = grad_x_diff;
                    ovf_d   = grad_overflow;
                    iter_d  = iter_q + 1'b1;
                    state_d = StUpdate;
                end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                    status_d = 2'b11;
                    state_d  = StDone;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StUpdate: begin
                if (ovf_q) begin
                    status_d = 2'b10;
                    state_d  = StDone;
                end else begin
                    x_d   = x_sat;
                    sat_d = sat_q | clip;
                    if (diff_abs <= TOL) begin
                        status_d = 2'b00;
                        state_d  = StDone;
                    end else if (iter_q == ITER_W'(MAX_ITER)) begin
                        status_d = 2'b01;
                        state_d  = StDone;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Results are registered on the way into DONE so they are valid with the done pulse
        if (state_d == StDone && state_q != StDone) begin
            x_opt_d = x_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            x_opt_q  <= '0;
            value_q  <= '0;
            diff_q   <= '0;
            ovf_q    <= 1'b0;
            iter_q   <= '0;
            status_q <= 2'b00;
            sat_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            x_opt_q  <= x_opt_d;
            value_q  <= value_d;
            diff_q   <= diff_d;
            ovf_q    <= ovf_d;
            iter_q   <= iter_d;
            status_q <= status_d;
            sat_q    <= sat_d;
            timer_q  <= timer_d;
        end
    end

    assign grad_start = state_q == StLaunch;
    assign grad_x     = x_q;
    assign busy       = state_q inside {StLaunch, StSettle, StWait, StUpdate};
    assign done       = state_q == StDone;
    assign x_opt      = x_opt_q;
    assign value_out  = value_q;
    assign iter_count = iter_q;
    assign status     = status_q;
    assign saturated  = sat_q;

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// Bench for gd_iter_ctrl: a per-run timeline model (launch/settle/wait/update cycle arithmetic)
// checked every cycle, with directed runs pinned by literal results and randomized runs.
module tb_gd_iter_ctrl;

    localparam int unsigned MAX_ITER = 8;
    localparam int unsigned ITER_W   = 16;
    localparam logic [31:0] TOL      = 32'h0000_0001;
    localparam int unsigned SETTLE   = 2;
    localparam int unsigned TIMEOUT  = 64;
    localparam int          MAXC     = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       x_init;
    logic              grad_start;
    logic [31:0]       grad_x;
    logic              grad_done;
    logic [63:0]       grad_value;
    logic [31:0]       grad_x_diff;
    logic              grad_overflow;
    logic              busy;
    logic              done;
    logic [31:0]       x_opt;
    logic [63:0]       value_out;
    logic [ITER_W-1:0] iter_count;
    logic [1:0]        status;
    logic              saturated;

    always #5 clk = ~clk;

    gd_iter_ctrl #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W),
        .TOL      (TOL),
        .SETTLE   (SETTLE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x_init        (x_init),
        .grad_start    (grad_start),
        .grad_x        (grad_x),
        .grad_done     (grad_done),
        .grad_value    (grad_value),
        .grad_x_diff   (grad_x_diff),
        .grad_overflow (grad_overflow),
        .busy          (busy),
        .done          (done),
        .x_opt         (x_opt),
        .value_out     (value_out),
        .iter_count    (iter_count),
        .status        (status),
        .saturated     (saturated)
    );

    // Per-evaluation plan: step, overflow flag, WAIT cycles until done (0 = never), stale done
    logic [31:0] pd     [MAX_ITER];
    logic        po     [MAX_ITER];
    int          pw     [MAX_ITER];
    logic        pstale [MAX_ITER];
    logic [63:0] pv     [MAX_ITER];

    // Expected timeline for one run, indexed by cycles after the accepted start
    logic        e_gs    [MAXC];
    logic [31:0] e_gx    [MAXC];
    int          e_it    [MAXC];
    logic        d_sched [MAXC];
    int          d_idx   [MAXC];
    int          done_t;

    logic [31:0] f_x, f_xopt;
    logic [63:0] f_val;
    int          f_it;
    logic [1:0]  f_st;
    logic        f_sat;

    int mode;           // 0 none, 1 in run, 2 idle, 3 reset values
    int tcur;
    int obs_done_t;
    int n_pulses;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got %h expected %h", name, tcur, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mode == 1) begin
            chk("grad_start", grad_start, e_gs[tcur]);
            chk("grad_x", grad_x, e_gx[tcur]);
            chk("busy", busy, tcur < done_t);
            chk("done", done, tcur == done_t);
            chk("iter_count", iter_count, e_it[tcur]);
            if (done) begin
                obs_done_t = tcur;
                n_pulses++;
            end
            if (tcur == done_t) begin
                chk("x_opt", x_opt, f_xopt);
                chk("value_out", value_out, f_val);
                chk("status", status, f_st);
                chk("saturated", saturated, f_sat);
            end
        end else if (mode == 2) begin
            chk("idle_grad_start", grad_start, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_grad_x", grad_x, f_x);
            chk("idle_x_opt", x_opt, f_xopt);
            chk("idle_value", value_out, f_val);
            chk("idle_iter", iter_count, f_it);
            chk("idle_status", status, f_st);
            chk("idle_sat", saturated, f_sat);
        end else if (mode == 3) begin
            chk("rst_outputs", {grad_start, busy, done, status, saturated, iter_count}, 0);
            chk("rst_x", {grad_x, x_opt}, 0);
            chk("rst_value", value_out, 0);
        end
    end

    // Build the expected timeline: launch at t, settle SETTLE, wait W, update at t+1+SETTLE+W
    task automatic build_model(input logic [31:0] xi, input logic hold_all);
        logic [31:0] x;
        logic [31:0] ad;
        longint      r;
        int          t, it, u, ws;
        logic        fin;
        x = xi; t = 0; it = 0; fin = 1'b0; f_sat = 1'b0; done_t = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_gs[c] = 1'b0; e_gx[c] = '0; e_it[c] = 0; d_sched[c] = hold_all; d_idx[c] = 0;
        end
        for (int k = 0; k < int'(MAX_ITER) && !fin; k++) begin
            ws = t + 1 + int'(SETTLE);
            e_gs[t] = 1'b1;
            if (pw[k] == 0) begin
                done_t = ws + int'(TIMEOUT);
                f_st = 2'b11;
                for (int c = t; c <= done_t; c++) begin
                    e_gx[c] = x; e_it[c] = it; d_idx[c] = k;
                end
                fin = 1'b1;
            end else begin
                u = ws + pw[k];
                for (int c = t; c <= u; c++) begin
                    e_gx[c] = x; e_it[c] = (c == u) ? it + 1 : it; d_idx[c] = k;
                end
                if (!hold_all) begin
                    d_sched[u-1] = 1'b1;
                    if (pw[k] == 1 && pstale[k]) begin
                        for (int c = t + 1; c < ws; c++) d_sched[c] = 1'b1;
                    end
                    if (pstale[k]) d_sched[u] = 1'b1;
                end
                it++;
                f_val  = pv[k];
                done_t = u + 1;
                if (po[k]) begin
                    f_st = 2'b10;
                    fin  = 1'b1;
                end else begin
                    r = longint'($signed(x)) - longint'($signed(pd[k]));
                    if (r > 64'sd2147483647) begin
                        x = 32'h7FFF_FFFF; f_sat = 1'b1;
                    end else if (r < -64'sd2147483648) begin
                        x = 32'h8000_0000; f_sat = 1'b1;
                    end else begin
                        x = r[31:0];
                    end
                    if (pd[k] == 32'h8000_0000) ad = 32'h7FFF_FFFF;
                    else if (pd[k][31])         ad = -pd[k];
                    else                        ad = pd[k];
                    if (ad <= TOL) begin
                        f_st = 2'b00; fin = 1'b1;
                    end else if (it == int'(MAX_ITER)) begin
                        f_st = 2'b01; fin = 1'b1;
                    end else begin
                        t = u + 1;
                    end
                end
            end
        end
        e_gx[done_t] = x;
        e_it[done_t] = it;
        f_x = x; f_xopt = x; f_it = it;
    endtask

    task automatic drive(input int c);
        grad_done     = d_sched[c];
        grad_value    = pv[d_idx[c]];
        grad_x_diff   = pd[d_idx[c]];
        grad_overflow = po[d_idx[c]];
        start         = 1'($urandom_range(0, 1));
        x_init        = $urandom;
    endtask

    task automatic idle_inputs();
        start = 1'b0; grad_done = 1'b0; grad_overflow = 1'b0; x_init = $urandom;
    endtask

    task automatic plan_all(input logic [31:0] d, input int w);
        for (int k = 0; k < int'(MAX_ITER); k++) begin
            pd[k] = d; pw[k] = w; po[k] = 1'b0;
            pstale[k] = 1'($urandom_range(0, 1)); pv[k] = {$urandom, $urandom};
        end
    endtask

    // Called in an idle cycle just after a rising edge; returns in the idle cycle after done
    task automatic run_one(input logic [31:0] xi, input logic hold_all);
        start = 1'b1; x_init = xi; grad_done = 1'b0;
        @(posedge clk); #1;
        build_model(xi, hold_all);
        tcur = 0; mode = 1;
        drive(0);
        while (tcur < done_t) begin
            @(posedge clk); #1;
            tcur++;
            drive(tcur);
        end
        @(posedge clk); #1;
        mode = 2;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    int p0;

    initial begin
        mode = 0; tcur = 0; obs_done_t = -1; n_pulses = 0;
        rst = 1'b1; start = 1'b0; x_init = '0; grad_done = 1'b0;
        grad_value = '0; grad_x_diff = '0; grad_overflow = 1'b0;
        f_x = '0; f_xopt = '0; f_val = '0; f_it = 0; f_st = 2'b00; f_sat = 1'b0;
        @(posedge clk); #1; mode = 3;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; mode = 2;
        @(posedge clk); #1;

        // Three steps of 0x10 then 0x01 from 0x100
        plan_all(32'h10, 2); pd[3] = 32'h1; pw[1] = 1; pw[2] = 4;
        p0 = n_pulses;
        run_one(32'h100, 1'b0);
        chk("tp1_x_opt", x_opt, 64'hCF);
        chk("tp1_iter", iter_count, 4);
        chk("tp1_status", status, 2'b00);
        chk("tp1_pulses", n_pulses - p0, 1);

        plan_all(32'h10, 3);
        run_one(32'h0, 1'b0);
        chk("tp2_x_opt", x_opt, 64'hFFFFFF80);
        chk("tp2_iter", iter_count, 8);
        chk("tp2_status", status, 2'b01);

        plan_all(32'h7FFF_FFFF, 1);
        run_one(32'h8000_0010, 1'b0);
        chk("tp3_x_opt", x_opt, 64'h80000000);
        chk("tp3_sat", saturated, 1);
        chk("tp3_status", status, 2'b01);

        plan_all(32'h40, 2); po[0] = 1'b1;
        run_one(32'h300, 1'b0);
        chk("tp4_x_opt", x_opt, 64'h300);
        chk("tp4_iter", iter_count, 1);
        chk("tp4_status", status, 2'b10);

        plan_all(32'h40, 0);
        obs_done_t = -1;
        run_one(32'h1234, 1'b0);
        chk("tp5_done_cycle", obs_done_t, 67);
        chk("tp5_status", status, 2'b11);
        chk("tp5_iter", iter_count, 0);

        // grad_done held high throughout: each evaluation consumed once, after settling
        plan_all(32'h20, 1); pd[2] = 32'h0;
        run_one(32'h1000, 1'b1);
        chk("tp6_x_opt", x_opt, 64'hFC0);
        chk("tp6_iter", iter_count, 3);

        // Reset while in WAIT
        plan_all(32'h40, 4);
        start = 1'b1; x_init = 32'h5555; @(posedge clk); #1;
        build_model(32'h5555, 1'b0);
        tcur = 0; mode = 1; drive(0);
        while (tcur < int'(SETTLE) + 1) begin
            @(posedge clk); #1; tcur++; drive(tcur);
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1; mode = 3; rst = 1'b0; grad_done = 1'b1;
        f_x = '0; f_xopt = '0; f_val = '0; f_it = 0; f_st = 2'b00; f_sat = 1'b0;
        @(posedge clk); #1; mode = 2; idle_inputs();
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            logic hold;
            logic [31:0] xi;
            hold = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < int'(MAX_ITER); k++) begin
                case ($urandom_range(0, 3))
                    0:       pd[k] = 32'($signed($urandom_range(0, 2)) - 1);
                    1:       pd[k] = {$urandom_range(0, 1) ? 4'hF : 4'h0, 28'($urandom)};
                    default: pd[k] = 32'($signed($urandom_range(0, 512)) - 256);
                endcase
                if ($urandom_range(0, 15) == 0) pd[k] = 32'h8000_0000;
                po[k]     = ($urandom_range(0, 15) == 0);
                pw[k]     = hold ? 1 : (($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4));
                pstale[k] = 1'($urandom_range(0, 1));
                pv[k]     = {$urandom, $urandom};
            end
            case ($urandom_range(0, 3))
                0:       xi = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                1:       xi = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: xi = $urandom;
            endcase
            run_one(xi, hold);
        end

        mode = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gd_iter_ctrl.md
# gd_iter_ctrl

Iteration controller for the gradient descent regressor. It owns the x register and drives the shared gradient/value unit (`func_grad_val_diff`): one start pulse per evaluation, collect value and `x_diff`, update x. It repeats until convergence, iteration limit, arithmetic overflow or evaluation timeout, then reports the final x, the final value and a status code. It sits between the host/config logic and the gradient unit.

## Interface
- `MAX_ITER`, 16'd256: maximum evaluations per run (1..2^ITER_W-1).
- `ITER_W`, 16: width of the iteration counter.
- `TOL`, 32'h00000001: Q24.8 convergence tolerance on |x_diff|.
- `SETTLE`, 2: cycles after `grad_start` during which `grad_done` is ignored (stale done level).
- `TIMEOUT`, 1024: maximum cycles in WAIT per evaluation.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: run request, sampled only in IDLE.
- `x_init` in 32: Q24.8 starting point, captured on accepted `start`.
- `grad_start` out 1: one-cycle start pulse to the gradient unit.
- `grad_x` out 32: Q24.8 evaluation point, held stable from LAUNCH through WAIT.
- `grad_done` in 1: gradient unit done (level, may stay high).
- `grad_value` in 64: Q56.8 f(x).
- `grad_x_diff` in 32: Q24.8 step (learning rate × gradient, already capped).
- `grad_overflow` in 1: arithmetic overflow in gradient unit.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: one-cycle pulse when results are valid.
- `x_opt` out 32: final x.
- `value_out` out 64: `grad_value` of the last completed evaluation.
- `iter_count` out ITER_W: evaluations completed in this run.
- `status` out 2: 00 converged, 01 max_iter, 10 overflow, 11 timeout.
- `saturated` out 1: sticky; x update clipped at least once this run.

## Operation
- States: IDLE, LAUNCH, SETTLE, WAIT, UPDATE, DONE.
- IDLE: on `start`, load x ← `x_init`, clear `iter_count`, `saturated` and the timers, then go to LAUNCH. `start` in any other state is ignored.
- LAUNCH: one cycle. `grad_start`=1, `grad_x`=x. Go to SETTLE.
- SETTLE: count `SETTLE` cycles, then go to WAIT. `grad_done` is ignored here.
- WAIT: on `grad_done`=1, capture `grad_value` and `grad_x_diff`, increment `iter_count`, go to UPDATE. If the timer reaches `TIMEOUT` first, go to DONE with status=11.
- UPDATE: one cycle, evaluated in priority order:
  1. If captured overflow: status=10, x unchanged, go to DONE.
  2. Otherwise x ← sat32(x − x_diff), computed in 33 bits. Clip to 0x7FFFFFFF / 0x80000000 and set `saturated` on clip.
  3. If |x_diff| ≤ `TOL`: status=00, go to DONE. |0x80000000| is taken as 0x7FFFFFFF.
  4. Else if `iter_count` = `MAX_ITER`: status=01, go to DONE.
  5. Else go to LAUNCH.
- Convergence and max_iter true in the same cycle: converged wins.
- DONE: `done`=1 for one cycle, `x_opt`←x, then IDLE. `x_opt`, `value_out`, `iter_count`, `status` and `saturated` hold until the next accepted `start`.

## Timing
- Reset state: IDLE. All outputs 0: `grad_start`, `grad_x`, `busy`, `done`, `x_opt`, `value_out`, `iter_count`, `status`, `saturated`.
- `start` at edge n → LAUNCH at n+1 (`grad_start` high that cycle) → SETTLE n+2..n+1+SETTLE → WAIT.
- Per-evaluation cycles: 1 + SETTLE + W + 1, where W ≥ 1 cycles are spent in WAIT. `done` rises the cycle after the final UPDATE.
- Back-to-back runs: `start` asserted during the `done` cycle is ignored. It is accepted the following cycle in IDLE.
- `rst` in any state returns to IDLE on the next edge with all outputs at reset values. `grad_start` is never asserted the cycle after `rst`.
- `grad_x` changes only in UPDATE, or on load in IDLE.

## Test plan
- Bench model returns x_diff=0x10 three times, then 0x01. `x_init`=0x100 → x goes 0xF0, 0xE0, 0xD0, 0xCF. Required: `x_opt`=0x000000CF, `iter_count`=4, status=00, one `done` pulse.
- `MAX_ITER`=8, constant x_diff=0x10, `x_init`=0 → `x_opt`=0xFFFFFF80, `iter_count`=8, status=01.
- `x_init`=0x80000010, x_diff=0x7FFFFFFF, `MAX_ITER`=1 → `x_opt`=0x80000000, `saturated`=1, status=01.
- First evaluation with `grad_overflow`=1, `x_init`=0x300 → `x_opt`=0x300, `iter_count`=1, status=10.
- `grad_done` never asserted → `done` pulses after exactly 1+SETTLE+TIMEOUT cycles in LAUNCH/SETTLE/WAIT, status=11, `iter_count`=0.
- `grad_done` held high continuously → each evaluation is consumed once, only after SETTLE. `rst` asserted in WAIT → next cycle all outputs 0 and state IDLE.
